seg7_scan_display: RTL and testbench
====================================

Name: seg7_scan_display

Overview:
- Parametrised, time-multiplexed hex display driver: captures an N-digit hex word on a load strobe, scans one digit at a time through a shared 7-segment bus with one-hot digit enables.
- Successor to the static one-decoder-per-digit HEX display path. Adds digit count and scan rate as parameters, a shadow register, optional leading-zero blanking and frame timing.
- Sits between the processor debug/result bus and the board's segment and digit-select pins.

Parameters:
- DIGITS, 8, number of hex digits displayed; data width is 4*DIGITS; legal range 1..16.
- SCAN_DIV, 50000, clk cycles each digit stays enabled; legal range >=1.
- ACTIVE_LOW, 1, 1: segments and digit enables are driven low-true; 0: high-true.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  4*DIGITS  hex value; nibble k drives digit k (digit 0 = bits [3:0]).
- load  input  1  when high at an edge, shadow <= data_in.
- blank_lz  input  1  level; enables leading-zero blanking.
- seg  output  7  segment bus {g,f,e,d,c,b,a}, registered.
- dig_en  output  DIGITS  one-hot digit enable, registered.
- frame_done  output  1  one-cycle pulse when the scan wraps from digit DIGITS-1 to 0.

Behaviour:
- Reset: clock and reset ports are clk and reset; reset is synchronous and active-high, sampled on the rising edge of clk.
  - State cleared: shadow=0, prescale=0, idx=0.
  - Outputs cleared: seg=all segments off (7'h7F if ACTIVE_LOW, else 7'h00), dig_en=all off (all ones if ACTIVE_LOW, else zero), frame_done=0.
  - Reset has priority over load and scan advance.
- Prescaler: width max(1,$clog2(SCAN_DIV)); counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1: prescale <= 0, idx advances.
  - idx wraps DIGITS-1 -> 0. With SCAN_DIV=1, idx advances every cycle.
- frame_done: asserted on the cycle after the edge where idx wraps DIGITS-1 -> 0; high for exactly 1 cycle. DIGITS=1: pulses on every advance.
- Shadow: load=1 captures data_in that edge. data_in is ignored while load=0. Back-to-back loads: the last one wins.
- Output pipeline: each edge, seg <= decode(shadow nibble[idx]) and dig_en <= onehot(idx), both using pre-edge register values.
  - load -> seg latency: 2 edges.
  - idx change -> dig_en latency: 1 edge.
  - seg and dig_en always change on the same edge.
- Decode, active-high gfedcba:
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
  - ACTIVE_LOW inverts both seg and dig_en.
- Leading-zero blanking: with blank_lz=1, digit k (k>0) is blanked (seg off, dig_en still asserted) when nibbles k..DIGITS-1 are all zero.
  - Digit 0 is never blanked, so shadow=0 shows a single "0".
- A blank_lz change takes effect at the next output register update.
- Mid-frame load: scan position is unaffected; new digits appear as they are scanned. No tearing within a single digit slot beyond the 2-edge latency.

Optional Feature:
- Macro: SEG7_SCAN_BLINK_EN.
- Defined:
  - Adds input blink_mask [DIGITS-1:0] and a free-running blink phase that toggles every 64 frame_done pulses.
  - While the phase is 1, digits with blink_mask[k]=1 show seg off; dig_en is unchanged.
  - The blink phase resets to 0.
- Not defined: no blink_mask port, no blink logic; behaviour exactly as above.

Test Plan:
- Reset: DIGITS=8, SCAN_DIV=4, ACTIVE_LOW=1; hold reset 3 cycles -> seg=7'h7F, dig_en=8'hFF, frame_done=0.
- Scan order: load data_in=32'h76543210, then run 32 cycles -> each digit k is enabled for 4 cycles in order 0..7.
  - dig_en low bit k while seg = ~decode(k); digit 0 shows seg=7'h40.
  - frame_done pulses once, after the digit-7 slot.
- Blanking: load 32'h000000A5, blank_lz=1 -> digits 0,1 show ~5 (7'h12) and ~A (7'h08); digits 2..7 seg=7'h7F.
  - Load 0 -> only digit 0 shows 7'h40.
- Latency: SCAN_DIV=1, DIGITS=1; load 4'hF at edge n -> seg=~7'h71=7'h0E after edge n+1.
- Reset mid-operation: assert reset together with load=1 at idx=5 -> shadow stays 0, idx=0, outputs blank next cycle.
  - Scan restarts from digit 0.
- ACTIVE_LOW=0, data 4'h8 on digit 0 -> seg=7'h7F, dig_en[0]=1 during its slot.

Source files
------------

// File: rtl/seg7_scan_display_if.sv
// Bus between a producer of hex values and the scanned 7-segment display driver.
// The blink_mask signal exists only when SEG7_SCAN_BLINK_EN is defined.
interface seg7_scan_display_if #(
  parameter int DIGITS = 8
);
  logic [4*DIGITS-1:0] data_in;
  logic                load;
  logic                blank_lz;
`ifdef SEG7_SCAN_BLINK_EN
  logic [DIGITS-1:0]   blink_mask;
`endif
  logic [6:0]          seg;
  logic [DIGITS-1:0]   dig_en;
  logic                frame_done;

`ifdef SEG7_SCAN_BLINK_EN
  modport master (output data_in, load, blank_lz, blink_mask,
                  input  seg, dig_en, frame_done);
  modport slave  (input  data_in, load, blank_lz, blink_mask,
                  output seg, dig_en, frame_done);
`else
  modport master (output data_in, load, blank_lz,
                  input  seg, dig_en, frame_done);
  modport slave  (input  data_in, load, blank_lz,
                  output seg, dig_en, frame_done);
`endif
endinterface

// File: rtl/seg7_scan_display.sv
// Time-multiplexed hex display driver: shadow-registered N-digit word scanned onto a
// shared 7-segment bus. Optional per-digit blinking under SEG7_SCAN_BLINK_EN.
module seg7_scan_display #(
  parameter int DIGITS     = 8,
  parameter int SCAN_DIV   = 50000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              reset,
  seg7_scan_display_if.slave bus
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0]     PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
  localparam logic [6:0]        SEG_OFF  = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0] DIG_OFF  = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}}
                                                             : {DIGITS{1'b0}};

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    unique case (nib)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  logic [4*DIGITS-1:0] shadow;
  logic [PW-1:0]       prescale;
  logic [IW-1:0]       idx;
  logic [6:0]          seg_q;
  logic [DIGITS-1:0]   dig_en_q;
  logic                frame_done_q;

  logic                advance;
  logic                wrap;
  logic [4*DIGITS-1:0] shifted;
  logic                blank;
  logic [6:0]          seg_d;
  logic [DIGITS-1:0]   dig_d;

`ifdef SEG7_SCAN_BLINK_EN
  logic [5:0] blink_cnt;
  logic       blink_phase;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    advance = (prescale == PRE_LAST);
    wrap    = advance && (idx == IDX_LAST);
    // Shifting the shadow down to the scanned digit gives both its nibble and, via the
    // all-zero test, whether every more significant digit is zero.
    shifted = shadow >> {idx, 2'b00};
    blank   = bus.blank_lz && (idx != '0) && (shifted == '0);
`ifdef SEG7_SCAN_BLINK_EN
    if (blink_phase && bus.blink_mask[idx]) blank = 1'b1;
`endif
    seg_d = blank ? 7'h00 : decode(shifted[3:0]);
    dig_d = DIGITS'(1) << idx;
    if (ACTIVE_LOW != 0) begin
      seg_d = ~seg_d;
      dig_d = ~dig_d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; seg and dig_en therefore track the same idx on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow       <= '0;
      prescale     <= '0;
      idx          <= '0;
      seg_q        <= SEG_OFF;
      dig_en_q     <= DIG_OFF;
      frame_done_q <= 1'b0;
    end else begin
      if (bus.load) shadow <= bus.data_in;
      if (advance) begin
        prescale <= '0;
        idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        prescale <= prescale + 1'b1;
      end
      seg_q        <= seg_d;
      dig_en_q     <= dig_d;
      frame_done_q <= wrap;
    end
  end

`ifdef SEG7_SCAN_BLINK_EN
  // Phase flips after every 64th frame_done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_done_q) begin
      blink_cnt <= blink_cnt + 1'b1;
      if (blink_cnt == 6'd63) blink_phase <= ~blink_phase;
    end
  end
`endif

  assign bus.seg        = seg_q;
  assign bus.dig_en     = dig_en_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Self-checking bench for seg7_scan_display: three configurations checked every cycle
// against an arithmetic model, plus hand-computed literal expectations.
module tb_seg7_scan_display;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seg7_scan_display_if #(.DIGITS(8)) if_a ();
  seg7_scan_display_if #(.DIGITS(1)) if_b ();
  seg7_scan_display_if #(.DIGITS(2)) if_c ();

  seg7_scan_display #(.DIGITS(8), .SCAN_DIV(4), .ACTIVE_LOW(1)) u_a (
    .clk(clk), .reset(reset), .bus(if_a));
  seg7_scan_display #(.DIGITS(1), .SCAN_DIV(1), .ACTIVE_LOW(1)) u_b (
    .clk(clk), .reset(reset), .bus(if_b));
  seg7_scan_display #(.DIGITS(2), .SCAN_DIV(2), .ACTIVE_LOW(0)) u_c (
    .clk(clk), .reset(reset), .bus(if_c));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: digit shown after e clean edges is (e-1)/SCAN_DIV mod DIGITS, using the
  // shadow value held before that edge.
  localparam int P_DIG [3] = '{8, 1, 2};
  localparam int P_DIV [3] = '{4, 1, 2};
  localparam int P_AL  [3] = '{1, 1, 0};
  localparam logic [6:0] FONT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                       7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic [63:0] m_sh  [3];
  int          m_e   [3];
  logic [15:0] m_seg [3];
  logic [15:0] m_en  [3];
  logic        m_fd  [3];
  bit          m_valid = 1'b0;

  task automatic model_step(input int i, input logic ld, input logic [63:0] d, input logic bl);
    int          idx;
    logic [63:0] upper;
    logic [6:0]  s;
    logic [15:0] en;
    logic [15:0] dmask;
    dmask = (16'(1) << P_DIG[i]) - 16'd1;
    if (reset) begin
      m_sh[i]  = '0;
      m_e[i]   = 0;
      m_seg[i] = (P_AL[i] != 0) ? 16'h7F : 16'h00;
      m_en[i]  = (P_AL[i] != 0) ? dmask : 16'h0;
      m_fd[i]  = 1'b0;
    end else begin
      idx   = (m_e[i] / P_DIV[i]) % P_DIG[i];
      upper = m_sh[i] >> (4 * idx);
      s     = FONT[upper[3:0]];
      if (bl && idx > 0 && upper == 64'd0) s = 7'h00;
      en = 16'(1) << idx;
      if (P_AL[i] != 0) begin
        s  = ~s;
        en = ~en & dmask;
      end
      m_seg[i] = 16'(s);
      m_en[i]  = en;
      m_fd[i]  = ((m_e[i] + 1) % P_DIV[i] == 0) && (idx == P_DIG[i] - 1);
      m_e[i]++;
      if (ld) m_sh[i] = d;
    end
  endtask

  always @(posedge clk) begin
    model_step(0, if_a.load, 64'(if_a.data_in), if_a.blank_lz);
    model_step(1, if_b.load, 64'(if_b.data_in), if_b.blank_lz);
    model_step(2, if_c.load, 64'(if_c.data_in), if_c.blank_lz);
    m_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("a_seg",   16'(if_a.seg),        m_seg[0]);
      check("a_dig",   16'(if_a.dig_en),     m_en[0]);
      check("a_frame", 16'(if_a.frame_done), 16'(m_fd[0]));
      check("b_seg",   16'(if_b.seg),        m_seg[1]);
      check("b_dig",   16'(if_b.dig_en),     m_en[1]);
      check("b_frame", 16'(if_b.frame_done), 16'(m_fd[1]));
      check("c_seg",   16'(if_c.seg),        m_seg[2]);
      check("c_dig",   16'(if_c.dig_en),     m_en[2]);
      check("c_frame", 16'(if_c.frame_done), 16'(m_fd[2]));
    end
  end

  // Advance to the falling edge that follows the n-th clean edge of instance A.
  task automatic goto(input int n);
    int guard = 0;
    while (m_e[0] < n && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (m_e[0] != n) begin
      n_cmp++;
      n_err++;
      $display("FAIL goto: edge count %0d, wanted %0d", m_e[0], n);
    end
  endtask

  task automatic lit_a(input string name, input logic [6:0] s, input logic [7:0] en);
    check({name, "_seg"}, 16'(if_a.seg), 16'(s));
    check({name, "_dig"}, 16'(if_a.dig_en), 16'(en));
  endtask

  initial begin
    int pulses;
    reset = 1'b1;
    if_a.data_in = '0; if_a.load = 1'b0; if_a.blank_lz = 1'b0;
    if_b.data_in = '0; if_b.load = 1'b0; if_b.blank_lz = 1'b0;
    if_c.data_in = '0; if_c.load = 1'b0; if_c.blank_lz = 1'b0;
`ifdef SEG7_SCAN_BLINK_EN
    if_a.blink_mask = '0; if_b.blink_mask = '0; if_c.blink_mask = '0;
`endif
    repeat (3) @(negedge clk);
    lit_a("reset_a", 7'h7F, 8'hFF);
    check("reset_a_frame", 16'(if_a.frame_done), 16'h0);
    check("reset_c_seg", 16'(if_c.seg), 16'h00);
    check("reset_c_dig", 16'(if_c.dig_en), 16'h0);

    // Scan order
    reset = 1'b0;
    if_a.data_in = 32'h76543210; if_a.load = 1'b1;
    if_c.data_in = 8'h08;        if_c.load = 1'b1;
    @(negedge clk);
    if_a.load = 1'b0; if_c.load = 1'b0;
    pulses = 0;
    for (int e = 2; e <= 33; e++) begin
      @(negedge clk);
      if (if_a.frame_done) pulses++;
      if (e == 2) begin
        lit_a("scan_d0", 7'h40, 8'hFE);
        check("al0_d0_seg", 16'(if_c.seg), 16'h7F);
        check("al0_d0_dig", 16'(if_c.dig_en), 16'h1);
      end
      if (e == 4) begin
        check("al0_d1_seg", 16'(if_c.seg), 16'h3F);
        check("al0_d1_dig", 16'(if_c.dig_en), 16'h2);
      end
      if (e == 14) lit_a("scan_d3", 7'h30, 8'hF7);
      if (e == 30) lit_a("scan_d7", 7'h78, 8'h7F);
    end
    check("frame_pulses", 16'(pulses), 16'd1);

    // Leading-zero blanking
    if_a.data_in = 32'h000000A5; if_a.load = 1'b1; if_a.blank_lz = 1'b1;
    goto(34);
    if_a.load = 1'b0;
    goto(37); lit_a("blank_d1", 7'h08, 8'hFD);
    goto(41); lit_a("blank_d2", 7'h7F, 8'hFB);
    goto(65); lit_a("blank_d0", 7'h12, 8'hFE);
    goto(70);
    if_a.data_in = 32'h0; if_a.load = 1'b1;
    goto(71);
    if_a.load = 1'b0;
    goto(73);  lit_a("zero_d2", 7'h7F, 8'hFB);
    goto(97);  lit_a("zero_d0", 7'h40, 8'hFE);
    goto(101); lit_a("zero_d1", 7'h7F, 8'hFD);

    // Load-to-seg latency on the one-digit, undivided instance
    if_b.data_in = 4'hF; if_b.load = 1'b1;
    goto(102);
    if_b.load = 1'b0;
    check("lat_n_seg", 16'(if_b.seg), 16'h40);
    goto(103);
    check("lat_n1_seg", 16'(if_b.seg), 16'h0E);
    check("lat_n1_dig", 16'(if_b.dig_en), 16'h0);

    // Reset with a simultaneous load while digit 5 is selected
    goto(116);
    reset = 1'b1;
    if_a.data_in = 32'hFFFFFFFF; if_a.load = 1'b1;
    @(negedge clk);
    lit_a("midrst", 7'h7F, 8'hFF);
    check("midrst_frame", 16'(if_a.frame_done), 16'h0);
    reset = 1'b0; if_a.load = 1'b0;
    @(negedge clk);
    lit_a("restart_d0", 7'h40, 8'hFE);
    goto(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
